// File: rtl/oam_dma_ctrl_pkg.sv
// rtl/oam_dma_ctrl_pkg.sv - shared types and constants for the OAM DMA controller
package oam_dma_ctrl_pkg;

    typedef enum logic [1:0] {
        H_BLANK = 2'd0,
        V_BLANK = 2'd1,
        SCAN    = 2'd2,
        DRAW    = 2'd3
    } PPU_STATES_t;

    typedef enum logic [2:0] {
        IDLE,
        START,
        XFER_RD,
        XFER_LAT,
        XFER_WR,
        XFER_GAP
    } DMA_STATES_t;

    localparam logic [15:0] OAM_BASE_ADDR = 16'hFE00;
    localparam int          OAM_LEN       = 160;
    localparam logic [15:0] DMA_REG_ADDR  = 16'hFF46;

    // Pages E0..FF alias the work RAM at C0..DF.
    function automatic logic [7:0] remap_src_hi(input logic [7:0] value);
        return (value >= 8'hE0) ? (value - 8'h20) : value;
    endfunction

endpackage

// File: rtl/dma_slot_timer.sv
// rtl/dma_slot_timer.sv - down-counter marking start-delay and byte-slot boundaries
module dma_slot_timer #(
    parameter int WIDTH = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             load,
    input  logic [WIDTH-1:0] load_val,
    output logic             done
);

    logic [WIDTH-1:0] count;

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (load) begin
            count <= load_val;
        end else if (count != '0) begin
            count <= count - 1'b1;
        end
    end

    assign done = (count == '0);

endmodule

// File: rtl/oam_dma_ctrl.sv
// rtl/oam_dma_ctrl.sv - FF46-triggered 160-byte copy into OAM with CPU bus blocking
module oam_dma_ctrl
    import oam_dma_ctrl_pkg::*;
#(
    parameter int M_CYCLE     = 4,
    parameter int START_DELAY = 4
) (
    input  logic        clk,
    input  logic        rst,
    input  logic [15:0] ADDR,
    input  logic        WR,
    input  logic        RD,
    input  logic [7:0]  MMIO_DATA_out,
    input  logic [1:0]  PPU_MODE,
    output logic        DMA_RD,
    output logic        DMA_WR,
    output logic [15:0] DMA_ADDR,
    input  logic [7:0]  DMA_DATA_in,
    output logic [7:0]  DMA_DATA_out,
    output logic        DMA_ACTIVE,
    output logic        CPU_BLOCK,
    output logic        OAM_LOCK
);

    localparam int TMAX = (M_CYCLE > START_DELAY) ? M_CYCLE : START_DELAY;
    localparam int TW   = $clog2(TMAX + 1);

    DMA_STATES_t state, state_n;
    logic [7:0]  idx, idx_n;
    logic [7:0]  src_hi, src_hi_n;
    logic [7:0]  byte_q, byte_n;
    logic        trigger;
    logic        tmr_load;
    logic [TW-1:0] tmr_val;
    logic        tmr_done;
    logic        rd_n, wr_n, active_n;
    logic [15:0] addr_n;
    logic [7:0]  data_n;

    dma_slot_timer #(.WIDTH(TW)) u_slot_timer (
        .clk      (clk),
        .rst      (rst),
        .load     (tmr_load),
        .load_val (tmr_val),
        .done     (tmr_done)
    );

    assign trigger = WR && (ADDR == DMA_REG_ADDR);

    // Outputs are registered from the next state so strobes line up with the state they belong to.
    always_comb begin
        state_n  = state;
        idx_n    = idx;
        src_hi_n = src_hi;
        byte_n   = byte_q;
        tmr_load = 1'b0;
        tmr_val  = TW'(M_CYCLE - 1);
        if (trigger) begin
            state_n  = START;
            idx_n    = 8'h00;
            src_hi_n = remap_src_hi(MMIO_DATA_out);
            tmr_load = 1'b1;
            tmr_val  = TW'(START_DELAY - 1);
        end else begin
            case (state)
                START: begin
                    if (tmr_done) begin
                        state_n  = XFER_RD;
                        tmr_load = 1'b1;
                    end
                end
                XFER_RD:  state_n = XFER_LAT;
                XFER_LAT: begin
                    state_n = XFER_WR;
                    byte_n  = DMA_DATA_in;
                end
                XFER_WR:  state_n = XFER_GAP;
                XFER_GAP: begin
                    if (tmr_done) begin
                        if (idx == 8'(OAM_LEN - 1)) begin
                            state_n = IDLE;
                        end else begin
                            state_n  = XFER_RD;
                            idx_n    = idx + 8'h01;
                            tmr_load = 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end

        rd_n     = (state_n == XFER_RD);
        wr_n     = (state_n == XFER_WR);
        active_n = (state_n != IDLE) && (state_n != START);
        addr_n   = 16'h0000;
        data_n   = 8'h00;
        if (rd_n) begin
            addr_n = {src_hi_n, idx_n};
        end else if (wr_n) begin
            addr_n = OAM_BASE_ADDR + {8'h00, idx_n};
            data_n = byte_n;
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state        <= IDLE;
            idx          <= 8'h00;
            src_hi       <= 8'h00;
            byte_q       <= 8'h00;
            DMA_RD       <= 1'b0;
            DMA_WR       <= 1'b0;
            DMA_ADDR     <= 16'h0000;
            DMA_DATA_out <= 8'h00;
            DMA_ACTIVE   <= 1'b0;
        end else begin
            state        <= state_n;
            idx          <= idx_n;
            src_hi       <= src_hi_n;
            byte_q       <= byte_n;
            DMA_RD       <= rd_n;
            DMA_WR       <= wr_n;
            DMA_ADDR     <= addr_n;
            DMA_DATA_out <= data_n;
            DMA_ACTIVE   <= active_n;
        end
    end

    // HRAM (FF80-FFFE) stays reachable and FF46 is never dropped, so a restart is always possible.
    assign CPU_BLOCK = DMA_ACTIVE && (RD || WR)
                       && !((ADDR >= 16'hFF80) && (ADDR <= 16'hFFFE))
                       && (ADDR != DMA_REG_ADDR);

    assign OAM_LOCK = DMA_ACTIVE || (PPU_MODE == SCAN) || (PPU_MODE == DRAW);

endmodule

// File: doc/oam_dma_ctrl.md
OAM_DMA_CTRL -- requirements
Module: oam_dma_ctrl

Interface
REQ-001 SHALL have parameter M_CYCLE, default 4, meaning clocks per byte transfer slot.
REQ-002 SHALL have parameter START_DELAY, default 4, meaning clocks from the FF46 write to the first source read.
REQ-003 SHALL have port clk, input, 1, system clock; the block uses this one clock only.
REQ-004 SHALL have port rst, input, 1, reset; synchronous, active-high.
REQ-005 SHALL have port ADDR, input, 16, CPU bus address.
REQ-006 SHALL have port WR, input, 1, CPU write strobe.
REQ-007 SHALL have port RD, input, 1, CPU read strobe.
REQ-008 SHALL have port MMIO_DATA_out, input, 8, CPU write data.
REQ-009 SHALL have port PPU_MODE, input, 2, PPU mode: 0 H_BLANK, 1 V_BLANK, 2 SCAN, 3 DRAW.
REQ-010 SHALL have port DMA_RD, output, 1, source read strobe.
REQ-011 SHALL have port DMA_WR, output, 1, OAM write strobe.
REQ-012 SHALL have port DMA_ADDR, output, 16, source address when DMA_RD=1; OAM address when DMA_WR=1.
REQ-013 SHALL have port DMA_DATA_in, input, 8, source read data, valid one clock after DMA_RD.
REQ-014 SHALL have port DMA_DATA_out, output, 8, byte written to OAM.
REQ-015 SHALL have port DMA_ACTIVE, output, 1, transfer in progress (states XFER_*).
REQ-016 SHALL have port CPU_BLOCK, output, 1, current CPU access must be dropped; reads return FF.
REQ-017 SHALL have port OAM_LOCK, output, 1, CPU OAM (FE00-FE9F) access forbidden.

Function
REQ-018 SHALL run the FSM IDLE -> START -> XFER_RD -> XFER_LAT -> XFER_WR -> XFER_GAP -> (XFER_RD | IDLE).
REQ-019 SHALL treat WR=1 with ADDR=FF46 as a trigger: latch src_hi=MMIO_DATA_out, clear idx, enter START.
REQ-020 SHALL remap the trigger value: src_hi >= E0 becomes src_hi - 20 (echo region).
REQ-021 SHALL hold START for START_DELAY clocks, then enter XFER_RD.
REQ-022 SHALL, in XFER_RD, drive DMA_RD=1 and DMA_ADDR={src_hi, idx} for exactly 1 clock.
REQ-023 SHALL, in XFER_LAT, capture DMA_DATA_in into a byte register.
REQ-024 SHALL, in XFER_WR, drive DMA_WR=1, DMA_ADDR=FE00+idx and DMA_DATA_out=the captured byte for 1 clock.
REQ-025 SHALL stay in XFER_GAP for M_CYCLE-3 clocks, so each byte takes exactly M_CYCLE clocks.
REQ-026 SHALL have idx 8 bits, ranging 0..159; after the write with idx=159 the FSM returns to IDLE and idx does not wrap.
REQ-027 SHALL be 160*M_CYCLE+START_DELAY clocks from the trigger to IDLE (644 at defaults).
REQ-028 SHALL restart on a trigger in any non-IDLE state: new src_hi, idx=0, START; any pending WR in the current slot is suppressed.
REQ-029 SHALL make a trigger win over slot completion when both occur in the same clock.
REQ-030 SHALL drive CPU_BLOCK=DMA_ACTIVE && (RD||WR) && ADDR outside FF80..FFFE && ADDR!=FF46; the FF46 trigger is always accepted.
REQ-031 SHALL drive OAM_LOCK=DMA_ACTIVE || PPU_MODE==2 || PPU_MODE==3.
REQ-032 SHALL hold DMA_RD and DMA_WR mutually exclusive and both 0 outside XFER_RD and XFER_WR.
REQ-033 SHALL drive DMA_ADDR=0000 and DMA_DATA_out=00 when neither strobe is active.
REQ-034 SHALL keep all outputs registered except CPU_BLOCK and OAM_LOCK, which are combinational.

Reset
REQ-035 SHALL, on rst=1 at a clk edge, set: state IDLE, idx 0, src_hi 00, byte register 00, DMA_RD 0, DMA_WR 0, DMA_ADDR 0000, DMA_DATA_out 00, DMA_ACTIVE 0.
REQ-036 SHALL abort a transfer on reset mid-transfer with no further strobes; the OAM contents already written are unchanged.
REQ-037 SHALL give rst priority over a simultaneous FF46 trigger.

Structure
REQ-038 SHALL place DMA_STATES_t (IDLE, START, XFER_RD, XFER_LAT, XFER_WR, XFER_GAP) in the shared package alongside PPU_STATES_t.
REQ-039 SHALL place OAM_BASE_ADDR (FE00), OAM_LEN (160) and DMA_REG_ADDR (FF46) in the shared package.
REQ-040 SHALL contain one natural sub-module, dma_slot_timer: a down-counter generating START_DELAY and M_CYCLE slot boundaries.

Verification
REQ-041 SHALL cover basic copy: source C000..C09F preloaded with i^5A, write FF46=C0 -> OAM FE00..FE9F equals i^5A; DMA_ACTIVE falls 644 clocks after the trigger.
REQ-042 SHALL cover echo remap: write FF46=E1 -> first DMA_RD has DMA_ADDR=C100.
REQ-043 SHALL cover restart: write FF46=C0, then FF46=D0 at idx=50 -> idx resets to 0; the final OAM matches D000..D09F; total time is 644 clocks from the second write.
REQ-044 SHALL cover blocking: during DMA, RD at 8000 -> CPU_BLOCK=1; RD at FF90 -> CPU_BLOCK=0; WR at FF46 -> accepted.
REQ-045 SHALL cover OAM lock: PPU_MODE=2 with no DMA -> OAM_LOCK=1; PPU_MODE=0 with no DMA -> 0; PPU_MODE=0 during DMA -> 1.
REQ-046 SHALL cover mid-transfer reset: rst asserted at idx=80 -> next clock IDLE, no DMA_WR afterwards, FE00..FE4F retain the copied data.
